bitty_fetch_unit: RTL

//  Instruction sequencer that drives the bitty core's instruction/run inputs and consumes its done pulse.

---
 rtl/bitty_pkg.sv | 17 +
 rtl/bitty_watchdog.sv | 31 +++
 rtl/bitty_fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// Shared constants and FSM encoding for the bitty fetch unit.
package bitty_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_MEM       = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

endpackage

// File: rtl/bitty_watchdog.sv
// Loadable down-counter with an expire flag; bounds how long the fetch unit
// waits for the core's done pulse. Only built when BITTY_FETCH_WATCHDOG_EN is defined.
`ifdef BITTY_FETCH_WATCHDOG_EN
module bitty_watchdog #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Load on request, otherwise count down while enabled and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule
`endif

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer for the bitty core: reads the synchronous ROM at pc,
// issues one word per run pulse, waits for done, advances pc, stops on the halt word.
// Optional done watchdog enabled by defining BITTY_FETCH_WATCHDOG_EN.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 8,
  parameter logic [INSTR_W-1:0]  HALT_WORD   = DEFAULT_HALT_WORD,
  parameter int unsigned         TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        instr_count,
  output logic               timeout_err
);

  state_t state;
  state_t state_nxt;
  logic   wd_expire;
  logic   restart;
  logic   is_halt_word;

  assign restart      = ((state == ST_IDLE) || (state == ST_HALTED)) && start;
  assign is_halt_word = (mem_data == HALT_WORD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done only matters while waiting on the core.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_MEM;
      ST_MEM:   state_nxt = is_halt_word ? ST_HALTED : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done)           state_nxt = ST_FETCH;
        else if (wd_expire) state_nxt = ST_HALTED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state only.
  assign mem_rd_en = (state == ST_FETCH);
  assign run       = (state == ST_ISSUE);
  assign busy      = (state == ST_FETCH) || (state == ST_MEM) ||
                     (state == ST_ISSUE) || (state == ST_WAIT_DONE);
  assign halted    = (state == ST_HALTED);
  assign mem_addr  = pc;

  // pc, held instruction word and saturating completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instruction <= '0;
      instr_count <= '0;
    end else begin
      if (restart) begin
        pc          <= '0;
        instr_count <= '0;
      end
      if ((state == ST_MEM) && !is_halt_word) begin
        instruction <= mem_data;
      end
      if ((state == ST_WAIT_DONE) && done) begin
        pc <= pc + ADDR_W'(1);
        if (instr_count != 16'hFFFF) begin
          instr_count <= instr_count + 16'd1;
        end
      end
    end
  end

`ifdef BITTY_FETCH_WATCHDOG_EN
  localparam int unsigned WD_CNT_W = $clog2(TIMEOUT_CYC + 1);

  // Watchdog reloads as the word issues, so it starts fresh on entry to WAIT_DONE.
  bitty_watchdog #(
    .CNT_W (WD_CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .en       (state == ST_WAIT_DONE),
    .load_val (WD_CNT_W'(TIMEOUT_CYC - 1)),
    .expire   (wd_expire)
  );

  // Sticky timeout flag; a done arriving on the expiry cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (restart) begin
      timeout_err <= 1'b0;
    end else if ((state == ST_WAIT_DONE) && !done && wd_expire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  // Timeout length is only meaningful when the watchdog is built.
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
